// File: rtl/tblink_rpc_rvarb.sv
// Packet-aware round-robin arbiter: merges N_PORTS tblink RPC byte streams
// onto one initiator stream, holding the grant for a whole packet.
module tblink_rpc_rvarb #(
  parameter int N_PORTS = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N_PORTS-1:0]   i_valid,
  output logic [N_PORTS-1:0]   i_ready,
  input  logic [8*N_PORTS-1:0] i_dat,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [7:0]           o_dat,
  output logic [2:0]           gnt_id,
  output logic                 busy,
  output logic                 pkt_done
);
  typedef enum logic [1:0] {IDLE, HDR, CNT, DATA} state_t;

  state_t                    state, state_nxt;
  logic [2:0]                rr_ptr, rr_nxt, gnt_nxt, win;
  logic [7:0]                count, count_nxt;
  logic [15:0]               vpad;
  logic [N_PORTS-1:0][7:0]   dat_arr;
  logic [3:0]                idx, gnt_inc;
  logic                      any, xfer, last;

  // valid padded to 16 bits so rotated indices never run off the vector
  assign vpad     = 16'(i_valid);
  assign dat_arr  = i_dat;
  assign busy     = (state != IDLE);
  assign o_valid  = busy & vpad[{1'b0, gnt_id}];
  assign xfer     = o_valid & o_ready;
  assign last     = (state == DATA) & (count == 8'd0);
  assign pkt_done = xfer & last;
  assign gnt_inc  = {1'b0, gnt_id} + 4'd1;

  always_comb begin
    o_dat = 8'h00;
    for (int k = 0; k < N_PORTS; k++)
      if (gnt_id == 3'(k)) o_dat = dat_arr[k];
  end

  for (genvar k = 0; k < N_PORTS; k++) begin : g_rdy
    assign i_ready[k] = busy & (gnt_id == 3'(k)) & o_ready;
  end

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    any = 1'b0;
    win = 3'd0;
    idx = 4'd0;
    for (int i = N_PORTS-1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + 4'(i);
      if (idx >= 4'(N_PORTS)) idx = idx - 4'(N_PORTS);
      if (vpad[idx]) begin
        any = 1'b1;
        win = idx[2:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    gnt_nxt   = gnt_id;
    count_nxt = count;
    case (state)
      IDLE: if (any) begin
        gnt_nxt   = win;
        state_nxt = HDR;
      end
      HDR:  if (xfer) state_nxt = CNT;
      CNT:  if (xfer) begin
        count_nxt = o_dat;
        state_nxt = DATA;
      end
      DATA: if (xfer) begin
        // exit test precedes the decrement, so C=255 yields 256 bytes
        if (last) begin
          rr_nxt    = (gnt_inc == 4'(N_PORTS)) ? 3'd0 : gnt_inc[2:0];
          state_nxt = IDLE;
        end else begin
          count_nxt = count - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rr_ptr <= 3'd0;
      gnt_id <= 3'd0;
      count  <= 8'd0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      gnt_id <= gnt_nxt;
      count  <= count_nxt;
    end
  end
endmodule

// File: tb/tb_tblink_rpc_rvarb.sv
// Directed bench for tblink_rpc_rvarb with two byte-queue sources and a
// transfer log compared against hand-built packet sequences.
module tb_tblink_rpc_rvarb;
  localparam int N = 2;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [N-1:0]     i_valid, i_ready;
  logic [8*N-1:0]   i_dat;
  logic             o_valid, o_ready;
  logic [7:0]       o_dat;
  logic [2:0]       gnt_id;
  logic             busy, pkt_done;

  tblink_rpc_rvarb #(.N_PORTS(N)) dut (
    .clock(clock), .reset_n(reset_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_dat(i_dat),
    .o_valid(o_valid), .o_ready(o_ready), .o_dat(o_dat),
    .gnt_id(gnt_id), .busy(busy), .pkt_done(pkt_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       ordy;
    logic       ov;
    logic [7:0] od;
    logic       bsy;
    logic [2:0] gid;
    logic       pd;
    logic [1:0] ir;
  } vec_t;

  logic [7:0] q0[$], q1[$];
  logic [7:0] log_d[$], exp_d[$];
  logic [2:0] log_g[$], exp_g[$];
  logic [N-1:0] src_en;
  logic rdy;
  logic s_ov, s_busy, s_pd;
  logic [7:0] s_od;
  logic [2:0] s_gnt;
  logic [1:0] s_ir;
  int checks = 0, errors = 0, pd_cnt = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic drive();
    i_valid[0]  = src_en[0] && (q0.size() > 0);
    i_valid[1]  = src_en[1] && (q1.size() > 0);
    i_dat[7:0]  = (q0.size() > 0) ? q0[0] : 8'h00;
    i_dat[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
    o_ready     = rdy;
  endtask

  // Sample mid-cycle, then pop whatever transferred on the following edge.
  task automatic tick();
    logic [N-1:0] x;
    @(negedge clock);
    x = i_valid & i_ready;
    s_ov = o_valid; s_od = o_dat; s_busy = busy;
    s_gnt = gnt_id; s_pd = pkt_done; s_ir = i_ready;
    if (o_valid && o_ready) begin
      log_d.push_back(o_dat);
      log_g.push_back(gnt_id);
    end
    if (pkt_done) pd_cnt++;
    @(posedge clock);
    #1;
    if (x[0]) void'(q0.pop_front());
    if (x[1]) void'(q1.pop_front());
    drive();
  endtask

  task automatic run_until_idle(input string n, input int max);
    logic done;
    done = 1'b0;
    for (int c = 0; c < max && !done; c++) begin
      tick();
      done = (q0.size() == 0) && (q1.size() == 0) && !s_busy;
    end
    chk({n, "_finish"}, 32'(done), 32'd1);
  endtask

  task automatic chk_log(input string n);
    chk({n, "_len"}, log_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < log_d.size(); i++) begin
      chk($sformatf("%s_dat%0d", n, i), 32'(log_d[i]), 32'(exp_d[i]));
      chk($sformatf("%s_gnt%0d", n, i), 32'(log_g[i]), 32'(exp_g[i]));
    end
  endtask

  task automatic clr_log();
    log_d.delete(); log_g.delete(); exp_d.delete(); exp_g.delete(); pd_cnt = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tv[7];
    logic       bp_rdy[10];
    logic [1:0] bp_ir[10];
    logic       bp_pd[10];

    // single packet from requester 0: bubble, then 05 02 A0 A1 A2
    tv[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 2'b00};
    tv[1] = '{1'b1, 1'b1, 8'h05, 1'b1, 3'd0, 1'b0, 2'b01};
    tv[2] = '{1'b1, 1'b1, 8'h02, 1'b1, 3'd0, 1'b0, 2'b01};
    tv[3] = '{1'b1, 1'b1, 8'hA0, 1'b1, 3'd0, 1'b0, 2'b01};
    tv[4] = '{1'b1, 1'b1, 8'hA1, 1'b1, 3'd0, 1'b0, 2'b01};
    tv[5] = '{1'b1, 1'b1, 8'hA2, 1'b1, 3'd0, 1'b1, 2'b01};
    tv[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 2'b00};

    bp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bp_ir  = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    bp_pd  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // reset state, with a requester already valid
    reset_n = 1'b0; rdy = 1'b1; src_en = 2'b11;
    q0.push_back(8'h99);
    drive();
    tick(); tick();
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_ov", 32'(s_ov), 32'd0);
    chk("rst_ir", 32'(s_ir), 32'd0);
    chk("rst_pd", 32'(s_pd), 32'd0);
    chk("rst_gnt", 32'(s_gnt), 32'd0);
    q0.delete();
    reset_n = 1'b1;

    // single packet, table driven
    clr_log();
    q0 = '{8'h05, 8'h02, 8'hA0, 8'hA1, 8'hA2};
    for (int i = 0; i < 7; i++) begin
      rdy = tv[i].ordy;
      drive();
      tick();
      chk($sformatf("sp%0d_ov", i), 32'(s_ov), 32'(tv[i].ov));
      if (tv[i].ov) chk($sformatf("sp%0d_od", i), 32'(s_od), 32'(tv[i].od));
      chk($sformatf("sp%0d_busy", i), 32'(s_busy), 32'(tv[i].bsy));
      if (tv[i].bsy) chk($sformatf("sp%0d_gnt", i), 32'(s_gnt), 32'(tv[i].gid));
      chk($sformatf("sp%0d_pd", i), 32'(s_pd), 32'(tv[i].pd));
      chk($sformatf("sp%0d_ir", i), 32'(s_ir), 32'(tv[i].ir));
    end

    // contention: rr_ptr=1 after requester 0 finished, so 1 goes first
    clr_log();
    q0 = '{8'h10, 8'h00, 8'hB0, 8'h12, 8'h00, 8'hB2};
    q1 = '{8'h21, 8'h00, 8'hC0, 8'h23, 8'h00, 8'hC1};
    drive();
    run_until_idle("rr", 60);
    exp_d = '{8'h21, 8'h00, 8'hC0, 8'h10, 8'h00, 8'hB0,
              8'h23, 8'h00, 8'hC1, 8'h12, 8'h00, 8'hB2};
    exp_g = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0,
              3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
    chk_log("rr");
    chk("rr_pd_cnt", pd_cnt, 4);

    // backpressure during CNT and DATA
    clr_log();
    q0 = '{8'h30, 8'h01, 8'hD0, 8'hD1};
    for (int i = 0; i < 10; i++) begin
      rdy = bp_rdy[i];
      drive();
      tick();
      chk($sformatf("bp%0d_ir", i), 32'(s_ir), 32'(bp_ir[i]));
      chk($sformatf("bp%0d_pd", i), 32'(s_pd), 32'(bp_pd[i]));
    end
    exp_d = '{8'h30, 8'h01, 8'hD0, 8'hD1};
    exp_g = '{3'd0, 3'd0, 3'd0, 3'd0};
    chk_log("bp");
    chk("bp_pd_cnt", pd_cnt, 1);

    // owner bubble: requester 1 stalls mid-payload while 0 waits
    clr_log();
    rdy = 1'b1;
    q1 = '{8'h41, 8'h03, 8'hE0, 8'hE1, 8'hE2, 8'hE3};
    q0 = '{8'h50, 8'h00, 8'hF0};
    drive();
    repeat (4) tick();
    src_en[1] = 1'b0;
    drive();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ob%0d_ov", i), 32'(s_ov), 32'd0);
      chk($sformatf("ob%0d_gnt", i), 32'(s_gnt), 32'd1);
      chk($sformatf("ob%0d_ir0", i), 32'(s_ir[0]), 32'd0);
      chk($sformatf("ob%0d_busy", i), 32'(s_busy), 32'd1);
    end
    src_en[1] = 1'b1;
    drive();
    run_until_idle("ob", 40);
    exp_d = '{8'h41, 8'h03, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'h50, 8'h00, 8'hF0};
    exp_g = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
    chk_log("ob");

    // maximum length: C=FF gives 256 payload bytes
    clr_log();
    q0 = '{8'h60, 8'hFF};
    exp_d = '{8'h60, 8'hFF};
    for (int i = 0; i < 256; i++) begin
      q0.push_back(8'(i));
      exp_d.push_back(8'(i));
    end
    for (int i = 0; i < 258; i++) exp_g.push_back(3'd0);
    drive();
    run_until_idle("max", 400);
    chk_log("max");
    chk("max_pd_cnt", pd_cnt, 1);

    // reset mid-packet (requester 1 in DATA, rr_ptr=1 beforehand)
    clr_log();
    q1 = '{8'h70, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    drive();
    repeat (5) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_ov", 32'(o_valid), 32'd0);
    chk("rm_ir", 32'(i_ready), 32'd0);
    tick(); tick();
    chk("rm_no_xfer", log_d.size(), 4);
    q1.delete();
    reset_n = 1'b1;
    clr_log();
    q0 = '{8'h80, 8'h00, 8'h90};
    q1 = '{8'h81, 8'h00, 8'h91};
    drive();
    run_until_idle("rm", 40);
    exp_d = '{8'h80, 8'h00, 8'h90, 8'h81, 8'h00, 8'h91};
    exp_g = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
    chk_log("rm");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
